// File: rtl/udp_tx_sched.sv
// Round-robin scheduler that shares one udp_tx engine between two packet sources.
// Each packet runs IDLE -> START -> WAIT_DONE -> GAP; outputs are registered except the read/data mux.
module udp_tx_sched #(
  parameter int unsigned GAP_CYCLES = 12,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch0_req,
  input  logic [10:0] ch0_len,
  input  logic [47:0] ch0_des_mac,
  input  logic [31:0] ch0_des_ip,
  input  logic [7:0]  ch0_data,
  output logic        ch0_ack,
  output logic        ch0_rd_en,
  output logic        ch0_done,
  output logic        ch0_err,
  input  logic        ch1_req,
  input  logic [10:0] ch1_len,
  input  logic [47:0] ch1_des_mac,
  input  logic [31:0] ch1_des_ip,
  input  logic [7:0]  ch1_data,
  output logic        ch1_ack,
  output logic        ch1_rd_en,
  output logic        ch1_done,
  output logic        ch1_err,
  output logic        udp_tx_en,
  output logic [10:0] udp_tx_data_num,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  output logic [7:0]  udp_odata,
  input  logic        udp_data_valid,
  input  logic        udp_tx_done,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  state_t      r_state;
  logic        r_gnt;
  logic        r_gnt_vld;
  logic        r_last;
  logic [1:0]  r_ack;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic        r_tx_en;
  logic [10:0] r_len;
  logic [47:0] r_mac;
  logic [31:0] r_ip;
  logic [15:0] r_timer;
  logic [15:0] r_gap_cnt;

  logic        w_any_req;
  logic        w_pick;
  logic [15:0] w_timer_nxt;

  // On a tie the channel that was not served last wins.
  assign w_any_req   = ch0_req | ch1_req;
  assign w_pick      = (ch0_req & ch1_req) ? ~r_last : ch1_req;
  assign w_timer_nxt = r_timer + 16'd1;

  // NOTE: every state register here takes a non-blocking assignment so all of them
  // update together at the edge; a blocking write would leak into later reads in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_gnt_vld <= 1'b0;
      r_last    <= 1'b1;
      r_ack     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      r_tx_en   <= 1'b0;
      r_len     <= '0;
      r_mac     <= '0;
      r_ip      <= '0;
      r_timer   <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_ack   <= 2'b00;
      r_done  <= 2'b00;
      r_err   <= 2'b00;
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt         <= w_pick;
            r_gnt_vld     <= 1'b1;
            r_last        <= w_pick;
            r_ack[w_pick] <= 1'b1;
            r_len         <= w_pick ? ch1_len     : ch0_len;
            r_mac         <= w_pick ? ch1_des_mac : ch0_des_mac;
            r_ip          <= w_pick ? ch1_des_ip  : ch0_des_ip;
            r_state       <= S_START;
          end
        end
        S_START: begin
          if (r_len == 11'd0) begin
            // Empty packets are dropped without ever starting the engine.
            r_done[r_gnt] <= 1'b1;
            r_err[r_gnt]  <= 1'b1;
            r_gnt_vld     <= 1'b0;
            r_gap_cnt     <= '0;
            r_state       <= S_GAP;
          end else begin
            r_tx_en <= 1'b1;
            r_timer <= '0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (udp_tx_done || (w_timer_nxt == TIMEOUT_V)) begin
            r_done[r_gnt] <= 1'b1;
            r_err[r_gnt]  <= ~udp_tx_done;
            r_gnt_vld     <= 1'b0;
            r_gap_cnt     <= '0;
            r_state       <= S_GAP;
          end else begin
            r_timer <= w_timer_nxt;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
          else                       r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch0_ack         = r_ack[0];
  assign ch1_ack         = r_ack[1];
  assign ch0_done        = r_done[0];
  assign ch1_done        = r_done[1];
  assign ch0_err         = r_err[0];
  assign ch1_err         = r_err[1];
  assign udp_tx_en       = r_tx_en;
  assign udp_tx_data_num = r_len;
  assign des_mac         = r_mac;
  assign des_ip          = r_ip;
  assign busy            = (r_state != S_IDLE);

  // Byte path follows the registered grant so the engine sees the owner's data with no added latency.
  assign ch0_rd_en = udp_data_valid & r_gnt_vld & ~r_gnt;
  assign ch1_rd_en = udp_data_valid & r_gnt_vld &  r_gnt;
  assign udp_odata = !r_gnt_vld ? 8'd0 : (r_gnt ? ch1_data : ch0_data);

endmodule

// File: tb/tb_udp_tx_sched.sv
// Self-checking bench for udp_tx_sched: a packet-timeline model predicts every output each cycle,
// directed scenarios pin latencies with literal values, then random sources and engine run.
module tb_udp_tx_sched;

  localparam int GAP = 12;
  localparam int TO  = 120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch0_req, ch1_req;
  logic [10:0] ch0_len, ch1_len;
  logic [47:0] ch0_des_mac, ch1_des_mac;
  logic [31:0] ch0_des_ip, ch1_des_ip;
  logic [7:0]  ch0_data, ch1_data;
  logic        ch0_ack, ch1_ack, ch0_rd_en, ch1_rd_en;
  logic        ch0_done, ch1_done, ch0_err, ch1_err;
  logic        udp_tx_en, udp_data_valid, udp_tx_done, busy;
  logic [10:0] udp_tx_data_num;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic [7:0]  udp_odata;

  udp_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_req(ch0_req), .ch0_len(ch0_len), .ch0_des_mac(ch0_des_mac), .ch0_des_ip(ch0_des_ip),
    .ch0_data(ch0_data), .ch0_ack(ch0_ack), .ch0_rd_en(ch0_rd_en), .ch0_done(ch0_done),
    .ch0_err(ch0_err),
    .ch1_req(ch1_req), .ch1_len(ch1_len), .ch1_des_mac(ch1_des_mac), .ch1_des_ip(ch1_des_ip),
    .ch1_data(ch1_data), .ch1_ack(ch1_ack), .ch1_rd_en(ch1_rd_en), .ch1_done(ch1_done),
    .ch1_err(ch1_err),
    .udp_tx_en(udp_tx_en), .udp_tx_data_num(udp_tx_data_num), .des_mac(des_mac),
    .des_ip(des_ip), .udp_odata(udp_odata), .udp_data_valid(udp_data_valid),
    .udp_tx_done(udp_tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Packet-timeline model: each granted packet is described by the edges at which its events occur.
  int          m_n = 0;
  bit          m_active = 0, m_gnt = 0, m_last = 1, m_err = 0;
  int          m_ack_e = -1, m_txen_e = -1, m_done_e = -1, m_free_e = 0;
  logic [10:0] m_len = '0;
  logic [47:0] m_mac = '0;
  logic [31:0] m_ip = '0;

  int n_checks = 0, n_pass = 0;
  int cnt_rd0 = 0, cnt_rd1 = 0, cnt_txen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_n);
  endtask

  task automatic model_step();
    m_n++;
    if (!rst_n) begin
      m_active = 0; m_gnt = 0; m_last = 1; m_err = 0;
      m_ack_e = -1; m_txen_e = -1; m_done_e = -1; m_free_e = 0;
      m_len = '0; m_mac = '0; m_ip = '0;
      return;
    end
    if (m_active) begin
      if (m_done_e < 0 && m_n > m_txen_e) begin
        if (udp_tx_done) begin m_done_e = m_n; m_err = 0; end
        else if (m_n == m_txen_e + TO) begin m_done_e = m_n; m_err = 1; end
      end
      if (m_n == m_done_e) begin m_active = 0; m_free_e = m_n + GAP + 1; end
    end else if (m_n >= m_free_e && (ch0_req || ch1_req)) begin
      m_gnt    = (ch0_req && ch1_req) ? !m_last : ch1_req;
      m_last   = m_gnt;
      m_active = 1;
      m_ack_e  = m_n;
      m_len    = m_gnt ? ch1_len : ch0_len;
      m_mac    = m_gnt ? ch1_des_mac : ch0_des_mac;
      m_ip     = m_gnt ? ch1_des_ip : ch0_des_ip;
      if (m_len == 0) begin m_txen_e = -1; m_done_e = m_n + 1; m_err = 1; end
      else begin m_txen_e = m_n + 1; m_done_e = -1; end
    end
  endtask

  // Compare process: advance the model at each edge, then check every output shortly after.
  initial begin
    bit ev_ack, ev_tx, ev_done;
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (rst_n) begin
        ev_ack  = (m_n == m_ack_e);
        ev_tx   = (m_n == m_txen_e);
        ev_done = (m_n == m_done_e);
        check("ch0_ack", ch0_ack, ev_ack && !m_gnt);
        check("ch1_ack", ch1_ack, ev_ack && m_gnt);
        check("udp_tx_en", udp_tx_en, ev_tx);
        check("ch0_done", ch0_done, ev_done && !m_gnt);
        check("ch1_done", ch1_done, ev_done && m_gnt);
        check("ch0_err", ch0_err, ev_done && !m_gnt && m_err);
        check("ch1_err", ch1_err, ev_done && m_gnt && m_err);
        check("busy", busy, m_active || (m_n < m_free_e - 1));
        check("ch0_rd_en", ch0_rd_en, udp_data_valid && m_active && !m_gnt);
        check("ch1_rd_en", ch1_rd_en, udp_data_valid && m_active && m_gnt);
        check("udp_tx_data_num", udp_tx_data_num, m_len);
        check("des_mac", des_mac, m_mac);
        check("des_ip", des_ip, m_ip);
        if (m_active) check("udp_odata", udp_odata, m_gnt ? ch1_data : ch0_data);
        cnt_rd0  += int'(ch0_rd_en);
        cnt_rd1  += int'(ch1_rd_en);
        cnt_txen += int'(udp_tx_en);
      end
    end
  end

  // Engine stand-in: answers udp_tx_en with done after a configured or random number of cycles.
  int eng_p_cfg = 0, eng_burst_cfg = 0;
  bit stray_en = 0;
  initial begin
    int cnt, burst_left;
    bit armed;
    armed = 0; cnt = 0; burst_left = 0;
    udp_tx_done = 0; udp_data_valid = 0; ch0_data = '0; ch1_data = '0;
    forever begin
      @(negedge clk);
      udp_tx_done = 0; udp_data_valid = 0;
      ch0_data = 8'($urandom); ch1_data = 8'($urandom);
      if (!rst_n) armed = 0;
      else if (udp_tx_en) begin
        armed = 1;
        cnt = (eng_p_cfg > 0) ? eng_p_cfg : int'($urandom_range(2, 150));
        cnt = cnt - 1;
        burst_left = eng_burst_cfg;
      end else if (armed) begin
        cnt--;
        if (cnt == 0) begin udp_tx_done = 1; armed = 0; end
        if (eng_burst_cfg > 0) begin
          if (burst_left > 0) begin udp_data_valid = 1; burst_left--; end
        end else udp_data_valid = 1'($urandom_range(0, 1));
      end else if (stray_en && $urandom_range(0, 19) == 0) udp_tx_done = 1;
    end
  end

  function automatic bit sig_sel(input int w);
    case (w)
      0:       return ch0_ack;
      1:       return ch1_ack;
      2:       return udp_tx_en;
      3:       return ch0_done;
      4:       return ch1_done;
      6:       return !busy;
      default: return ch0_ack | ch1_ack;
    endcase
  endfunction

  task automatic wait_ev(input string name, input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #3;
      if (sig_sel(which)) begin at = m_n; break; end
    end
    if (at < 0) begin
      n_checks++;
      $display("FAIL %s: event not seen within %0d cycles", name, limit);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, e, d, k_exp, r0, r1, tx0;
    int g[4], t[4];
    rst_n = 1'b1;
    ch0_req = 0; ch1_req = 0; ch0_len = '0; ch1_len = '0;
    ch0_des_mac = '0; ch1_des_mac = '0; ch0_des_ip = '0; ch1_des_ip = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags", {ch0_ack, ch1_ack, ch0_rd_en, ch1_rd_en, ch0_done, ch1_done,
                        ch0_err, ch1_err, udp_tx_en, busy}, 0);
    check("rst_data", {udp_tx_data_num, des_mac, des_ip}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single ch0 packet, engine finishes 100 cycles after udp_tx_en.
    eng_p_cfg = 100;
    ch0_req = 1; ch0_len = 11'd64; ch0_des_mac = 48'h0A1B_2C3D_4E5F; ch0_des_ip = 32'hC0A8_0164;
    k_exp = m_n + 1;
    wait_ev("t1_ack", 0, 10, a);
    check("t1_ack_edge", a, k_exp);
    @(negedge clk) ch0_req = 0;
    wait_ev("t1_txen", 2, 10, e);
    check("t1_txen_latency", e - a, 1);
    check("t1_data_num", udp_tx_data_num, 64);
    check("t1_des_mac", des_mac, 48'h0A1B_2C3D_4E5F);
    check("t1_des_ip", des_ip, 32'hC0A8_0164);
    wait_ev("t1_done", 3, 200, d);
    check("t1_done_latency", d - e, 100);
    check("t1_err", ch0_err, 0);

    // Both channels held: grants alternate starting with ch1 (ch0 was served last).
    wait_ev("t2_idle", 6, 50, a);
    @(negedge clk);
    eng_p_cfg = 30;
    ch0_req = 1; ch0_len = 11'd20; ch1_req = 1; ch1_len = 11'd30;
    for (int i = 0; i < 4; i++) begin
      wait_ev("t2_ack", 7, 100, a);
      g[i] = int'(ch1_ack);
      wait_ev("t2_txen", 2, 10, t[i]);
    end
    @(negedge clk) begin ch0_req = 0; ch1_req = 0; end
    for (int i = 0; i < 4; i++) check("t2_grant", g[i], (i % 2 == 0) ? 1 : 0);
    for (int i = 1; i < 4; i++) check("t2_spacing", t[i] - t[i-1], 30 + GAP + 2);

    // ch1 packet with 64 consecutive byte requests.
    wait_ev("t3_idle", 6, 100, a);
    @(negedge clk);
    eng_p_cfg = 100; eng_burst_cfg = 64;
    ch1_req = 1; ch1_len = 11'd64;
    wait_ev("t3_ack", 1, 10, a);
    r0 = cnt_rd0; r1 = cnt_rd1;
    @(negedge clk) ch1_req = 0;
    wait_ev("t3_done", 4, 200, d);
    check("t3_ch1_rd_count", cnt_rd1 - r1, 64);
    check("t3_ch0_rd_count", cnt_rd0 - r0, 0);
    eng_burst_cfg = 0;

    // Zero-length packet is dropped with an error and never starts the engine.
    wait_ev("t4_idle", 6, 50, a);
    @(negedge clk);
    ch0_req = 1; ch0_len = 11'd0;
    tx0 = cnt_txen;
    wait_ev("t4_ack", 0, 10, a);
    @(negedge clk) ch0_req = 0;
    wait_ev("t4_done", 3, 10, d);
    check("t4_done_latency", d - a, 1);
    check("t4_err", ch0_err, 1);
    wait_ev("t4_idle_after", 6, 50, e);
    check("t4_no_tx_en", cnt_txen - tx0, 0);

    // Engine never answers: timeout after TO cycles, then the next grant follows the gap.
    @(negedge clk);
    eng_p_cfg = 1000;
    ch0_req = 1; ch0_len = 11'd10;
    wait_ev("t5_ack", 0, 10, a);
    @(negedge clk) ch0_req = 0;
    wait_ev("t5_txen", 2, 10, e);
    wait_ev("t5_done", 3, TO + 20, d);
    check("t5_timeout_latency", d - e, TO);
    check("t5_err", ch0_err, 1);
    @(negedge clk);
    eng_p_cfg = 20;
    ch1_req = 1; ch1_len = 11'd16;
    wait_ev("t5_next_ack", 1, GAP + 10, a);
    check("t5_next_grant_edge", a - d, GAP + 1);
    @(negedge clk) ch1_req = 0;

    // Reset while waiting for done, then a tie goes to ch0.
    wait_ev("t6_txen", 2, 10, e);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_flags", {ch0_ack, ch1_ack, ch0_rd_en, ch1_rd_en, ch0_done, ch1_done,
                           ch0_err, ch1_err, udp_tx_en, busy}, 0);
    check("t6_rst_data", {udp_tx_data_num, des_mac, des_ip, udp_odata}, 0);
    ch0_req = 1; ch0_len = 11'd5; ch1_req = 1; ch1_len = 11'd6;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ev("t6_ack", 7, 10, a);
    check("t6_tie_ch0", ch0_ack, 1);
    check("t6_tie_ch1", ch1_ack, 0);
    @(negedge clk) begin ch0_req = 0; ch1_req = 0; end
    wait_ev("t6_idle", 6, 100, a);

    // Random sources, random engine timing, stray done pulses outside packets.
    eng_p_cfg = 0; stray_en = 1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (ch0_req) begin
        if (ch0_ack) begin
          ch0_req = 1'($urandom_range(0, 1));
          ch0_len = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
          ch0_des_mac = 48'({$urandom(), $urandom()}); ch0_des_ip = $urandom();
        end else if ($urandom_range(0, 39) == 0) ch0_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        ch0_req = 1;
        ch0_len = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
        ch0_des_mac = 48'({$urandom(), $urandom()}); ch0_des_ip = $urandom();
      end
      if (ch1_req) begin
        if (ch1_ack) begin
          ch1_req = 1'($urandom_range(0, 1));
          ch1_len = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
          ch1_des_mac = 48'({$urandom(), $urandom()}); ch1_des_ip = $urandom();
        end else if ($urandom_range(0, 39) == 0) ch1_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        ch1_req = 1;
        ch1_len = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
        ch1_des_mac = 48'({$urandom(), $urandom()}); ch1_des_ip = $urandom();
      end
    end
    @(negedge clk) begin ch0_req = 0; ch1_req = 0; end
    wait_ev("drain_idle", 6, 400, a);
    stray_en = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
